// File: rtl/pkt_stream_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pkt_stream_gen                                                   |
// | Purpose  : Burst test-word generator on valid/ready (table/inc/LFSR/const). |
// | Options  : PKTGEN_CHECKSUM_EN appends an XOR checksum word to each burst.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pkt_stream_gen #(
    parameter int                 DATA_W    = 16,
    parameter int                 MAX_LEN   = 256,
    parameter int                 LEN_W     = $clog2(MAX_LEN + 1),
    parameter logic [DATA_W-1:0]  SEQ_BASE  = DATA_W'(16'h100A),
    parameter int                 HEAD_N    = 10,
    parameter logic [DATA_W-1:0]  LFSR_TAPS = DATA_W'(16'hB400)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [LEN_W-1:0]  out_idx,
    output logic              busy,
    output logic              done
);

`ifdef PKTGEN_CHECKSUM_EN
    localparam bit c_CSUM_EN = 1'b1;
`else
    localparam bit c_CSUM_EN = 1'b0;
`endif
    localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] c_HEAD_N  = LEN_W'(HEAD_N);
    localparam logic [LEN_W-1:0] c_ONE     = LEN_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [1:0]        r_mode;
    logic [DATA_W-1:0] r_seed;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_csum;
    logic              r_valid;
    logic              r_last;
    logic              r_busy;
    logic              r_done;

    logic [LEN_W-1:0]  w_len_eff;
    logic [LEN_W-1:0]  w_nidx;
    logic [DATA_W-1:0] w_first;
    logic [DATA_W-1:0] w_next;
    logic              w_last_data;

    // Legacy fixed head of the dummy-packet table.
    function automatic logic [DATA_W-1:0] f_head(input logic [LEN_W-1:0] idx);
        logic [15:0] v;
        case (int'(idx))
            0:       v = 16'hAAAA;
            1:       v = 16'hBBBB;
            2:       v = 16'hCCCC;
            3:       v = 16'hDDDD;
            4:       v = 16'hEEEE;
            5:       v = 16'hFFFF;
            6:       v = 16'h1234;
            7:       v = 16'h5678;
            8:       v = 16'h9999;
            9:       v = 16'h2468;
            default: v = 16'h0000;
        endcase
        return DATA_W'(v);
    endfunction

    function automatic logic [DATA_W-1:0] f_word(
        input logic [1:0]        m,
        input logic [DATA_W-1:0] s,
        input logic [LEN_W-1:0]  idx,
        input logic [DATA_W-1:0] prev
    );
        logic [DATA_W-1:0] w;
        case (m)
            2'd0: w = (idx < c_HEAD_N) ? f_head(idx)
                                       : SEQ_BASE + DATA_W'(idx) - DATA_W'(c_HEAD_N);
            2'd1: w = s + DATA_W'(idx);
            2'd2: begin
                // The LFSR locks up at zero, so a zero seed starts from 1.
                if (idx == '0)
                    w = (s == '0) ? DATA_W'(1) : s;
                else
                    w = {1'b0, prev[DATA_W-1:1]} ^ (prev[0] ? LFSR_TAPS : '0);
            end
            default: w = s;
        endcase
        return w;
    endfunction

    always_comb begin
        w_len_eff = burst_len;
        if (burst_len == '0)
            w_len_eff = c_ONE;
        else if (burst_len > c_MAX_LEN)
            w_len_eff = c_MAX_LEN;
    end

    assign w_nidx      = r_idx + c_ONE;
    assign w_first     = f_word(mode, seed, '0, seed);
    assign w_next      = f_word(r_mode, r_seed, w_nidx, r_data);
    assign w_last_data = (r_idx == r_len - c_ONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mode  <= '0;
            r_seed  <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_csum  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_mode  <= mode;
                        r_seed  <= seed;
                        r_len   <= w_len_eff;
                        r_idx   <= '0;
                        r_data  <= w_first;
                        r_csum  <= '0;
                        r_valid <= 1'b1;
                        r_last  <= !c_CSUM_EN && (w_len_eff == c_ONE);
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // Abort wins over a same-cycle handshake: that word is dropped.
                    if (abort || (r_valid && out_ready && r_last)) begin
                        r_state <= S_DONE;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_valid && out_ready) begin
                        r_idx <= w_nidx;
                        if (c_CSUM_EN && w_last_data) begin
                            r_data <= r_csum ^ r_data;
                            r_last <= 1'b1;
                        end else begin
                            r_data <= w_next;
                            r_csum <= r_csum ^ r_data;
                            r_last <= !c_CSUM_EN && (w_nidx == r_len - c_ONE);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign out_idx   = r_idx;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: doc/pkt_stream_gen.md
Name: pkt_stream_gen

Overview:
- Synthesizable, parametrised successor to the fixed 100-entry 16-bit dummy-packet table used by buffer testbenches.
- Streams a programmable burst of test words over a valid/ready interface in one of four pattern modes. Drives FIFO/buffer inputs on-chip (hardware self-test) and in simulation.
- Sits upstream of any sample buffer under test. Its table mode reproduces the legacy sequence exactly.

Parameters:
- DATA_W, 16, output word width.
- MAX_LEN, 256, maximum burst length; counters are $clog2(MAX_LEN+1) bits (LEN_W).
- SEQ_BASE, 16'h100A, first value of the sequential region in table mode (zero-extended or truncated to DATA_W).
- HEAD_N, 10, number of fixed head entries in table mode (0..10).
- LFSR_TAPS, 16'hB400, Galois tap mask for LFSR mode (width DATA_W).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  single-cycle pulse that begins a burst; honoured only in IDLE or DONE
- abort  in  1  ends the burst immediately
- mode  in  2  0=table, 1=increment, 2=LFSR, 3=constant; sampled at start
- burst_len  in  LEN_W  number of words to emit; sampled at start; 0 treated as 1, values >MAX_LEN clamped
- seed  in  DATA_W  start value for modes 1–3; sampled at start
- out_data  out  DATA_W  current word
- out_valid  out  1  word valid
- out_ready  in  1  downstream accept
- out_last  out  1  high with the final word of the burst
- out_idx  out  LEN_W  index of the current word
- busy  out  1  FSM in RUN
- done  out  1  one-cycle pulse after the last handshake or on abort

Behaviour:
- Reset values: out_data=0, out_valid=0, out_last=0, out_idx=0, busy=0, done=0. FSM=IDLE. rst_n low mid-burst returns to IDLE on the next edge with no done pulse.
- FSM states:
  - IDLE: start -> RUN.
  - RUN: a handshake on the last word -> DONE. abort -> DONE.
  - DONE: the done pulse lasts 1 cycle. The next cycle goes to IDLE, or to RUN if start is asserted in DONE.
- Latency: out_valid rises 1 cycle after start, with word 0 on out_data.
- Handshake:
  - A transfer occurs when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable.
  - After each transfer the next word appears on the following cycle, so back-to-back throughput is 1 word/cycle.
- Pattern generation (i = out_idx):
  - Table mode: for i<HEAD_N, out_data = HEAD[i], where HEAD = AAAA, BBBB, CCCC, DDDD, EEEE, FFFF, 1234, 5678, 9999, 2468. For i≥HEAD_N, out_data = SEQ_BASE + (i−HEAD_N), mod 2^DATA_W.
  - Increment mode: seed + i, wrapping mod 2^DATA_W.
  - LFSR mode: word 0 = seed, with seed 0 forced to 1. Each next word = (s>>1) ^ (s[0] ? LFSR_TAPS : 0).
  - Constant mode: seed for every word.
- Boundary conditions:
  - out_last = (i == effective_len−1).
  - start while RUN is ignored.
  - abort takes priority over a handshake in the same cycle: the word is not counted and out_valid drops on the next edge.
  - abort in IDLE is ignored.

Optional Feature:
- PKTGEN_CHECKSUM_EN defined:
  - After the last data word, one extra word is emitted: the XOR of all data words in the burst.
  - out_last moves from the last data word to this checksum word.
  - out_idx = effective_len on the checksum word.
  - An abort skips the checksum.
- Undefined: no checksum word; out_last marks the last data word.

Test Plan:
- Table mode, burst_len=100, out_ready=1: word0=AAAA, word9=2468, word10=100A, word99=1063 with out_last=1. done pulses 1 cycle after word99; 100 words in 100 consecutive cycles.
- Increment mode, seed=FFFE, burst_len=4, random out_ready: FFFE, FFFF, 0000, 0001. Data is stable during every stall and no word is dropped or duplicated.
- LFSR mode, seed=0000, burst_len=3: 0001, B400, 5A00.
- abort asserted coincident with the handshake of word 5 of 20: word 5 is not counted, out_valid=0 the next cycle, done pulses, then IDLE.
- burst_len=0 in constant mode with seed=1234: exactly one word 1234 with out_last=1.
- PKTGEN_CHECKSUM_EN, increment mode, seed=0001, burst_len=3: 0001, 0002, 0003, then checksum 0000 with out_last=1 and out_idx=3.
